// File: rtl/maxpool_stream_if.sv
// Stream bus between the sequencer and the 2x2 max-pool engine.
//
// Handshake: valid-only, no ready. A word on DI is consumed on every rising
// edge where DI_valid=1. A pooled word on DO is meaningful only on the cycle
// DO_valid=1, and the consumer must take it on that cycle.
//
// master: sequencer side (drives DI, receives DO).
// slave : pooling engine side (receives DI, drives DO).
interface maxpool_stream_if #(
    parameter int DATA_W = 16
);
    logic              DI_valid;
    logic [DATA_W-1:0] DI;
    logic              DO_valid;
    logic [DATA_W-1:0] DO;

    modport master (output DI_valid, output DI, input DO_valid, input DO);
    modport slave  (input DI_valid, input DI, output DO_valid, output DO);
endinterface

// File: rtl/maxpool_stream.sv
// Streaming 2x2, stride-2 max-pool engine.
// Input arrives row-major, ROW_LEN words per row. Even rows fold each
// horizontal pair into a line buffer. Odd rows fold their pair with the
// buffered entry and emit one pooled word per window.
// Optional feature macro: MAXPOOL_STREAM_RELU_EN. When it is defined, negative
// results are clamped to zero if SIGNED != 0.
module maxpool_stream #(
    parameter int DATA_W  = 16,
    parameter int ROW_LEN = 16,
    parameter int SIGNED  = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    maxpool_stream_if.slave      bus,
    output logic                 odd_row,
    output logic [15:0]          pair_cnt
);
    localparam int              CW       = $clog2(ROW_LEN);
    localparam int              HALF     = ROW_LEN / 2;
    localparam logic [CW-1:0]   COL_LAST = CW'(ROW_LEN - 1);

    localparam logic [0:0] ST_EVEN = 1'b0;
    localparam logic [0:0] ST_ODD  = 1'b1;

    // Maximum of two words. On a tie both operands are equal, so either one is correct.
    function automatic logic [DATA_W-1:0] max2(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
        logic ge;
        if (SIGNED != 0) ge = ($signed(a) >= $signed(b));
        else             ge = (a >= b);
        return ge ? a : b;
    endfunction

    // Final output shaping, applied in the same cycle as the last compare
    function automatic logic [DATA_W-1:0] shape_out(input logic [DATA_W-1:0] r);
`ifdef MAXPOOL_STREAM_RELU_EN
        if ((SIGNED != 0) && r[DATA_W-1]) return '0;
        else                              return r;
`else
        return r;
`endif
    endfunction

    logic [0:0]        state_q, state_d;
    logic [CW-1:0]     col_q, col_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic              do_valid_q, do_valid_d;
    logic [DATA_W-1:0] do_q, do_d;
    logic [15:0]       pair_cnt_q, pair_cnt_d;
    logic [DATA_W-1:0] linebuf_q [HALF];
    logic [DATA_W-1:0] linebuf_d [HALF];

    logic [DATA_W-1:0] h;
    logic [DATA_W-1:0] lb_rd;

    // Horizontal pair maximum: the held even-column word against the incoming odd-column word
    always_comb begin
        h = max2(hold_q, bus.DI);
    end

    // Line buffer read at the current column pair
    always_comb begin
        lb_rd = '0;
        for (int i = 0; i < HALF; i++) begin
            if (i == int'(col_q >> 1)) lb_rd = linebuf_q[i];
        end
    end

    // Next state: column walk, even/odd row FSM, line buffer fill, pooled output
    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        hold_d     = hold_q;
        do_valid_d = 1'b0;
        do_d       = do_q;
        pair_cnt_d = pair_cnt_q;
        for (int i = 0; i < HALF; i++) linebuf_d[i] = linebuf_q[i];

        if (clear) begin
            // Resync to the start of a row pair. A word presented this cycle is dropped.
            col_d      = '0;
            state_d    = ST_EVEN;
            pair_cnt_d = '0;
        end else if (bus.DI_valid) begin
            if (!col_q[0]) begin
                hold_d = bus.DI;
            end else if (state_q == ST_EVEN) begin
                for (int i = 0; i < HALF; i++) begin
                    if (i == int'(col_q >> 1)) linebuf_d[i] = h;
                end
            end else begin
                do_d       = shape_out(max2(lb_rd, h));
                do_valid_d = 1'b1;
            end

            if (col_q == COL_LAST) begin
                col_d = '0;
                if (state_q == ST_EVEN) begin
                    state_d = ST_ODD;
                end else begin
                    state_d    = ST_EVEN;
                    pair_cnt_d = pair_cnt_q + 16'd1;
                end
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    // Control and output registers. The synchronous reset takes priority over clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_EVEN;
            col_q      <= '0;
            hold_q     <= '0;
            do_valid_q <= 1'b0;
            do_q       <= '0;
            pair_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            hold_q     <= hold_d;
            do_valid_q <= do_valid_d;
            do_q       <= do_d;
            pair_cnt_q <= pair_cnt_d;
        end
    end

    // Line buffer storage. Its contents are not needed after reset, so it has no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < HALF; i++) linebuf_q[i] <= linebuf_d[i];
    end

    assign bus.DO_valid = do_valid_q;
    assign bus.DO       = do_q;
    assign odd_row      = (state_q == ST_ODD);
    assign pair_cnt     = pair_cnt_q;

endmodule

// File: tb/tb_maxpool_stream.sv
// Directed bench for maxpool_stream. It uses three instances:
//   u4  : ROW_LEN=4,  unsigned
//   u2  : ROW_LEN=2,  signed
//   u16 : ROW_LEN=16, unsigned
// Expected pooled words are queued when the completing input word is driven.
// They are popped and compared when DO_valid is seen. Each cycle, DO_valid is
// also compared against the cycle on which a pulse is due.
module tb_maxpool_stream;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    maxpool_stream_if #(.DATA_W(16)) if4 ();
    maxpool_stream_if #(.DATA_W(16)) if2 ();
    maxpool_stream_if #(.DATA_W(16)) if16 ();

    logic rst4, rst2, rst16, clr4, clr2, clr16;
    logic odd4, odd2, odd16;
    logic [15:0] pc4, pc2, pc16;

    maxpool_stream #(.DATA_W(16), .ROW_LEN(4), .SIGNED(0)) u4 (
        .clk(clk), .rst(rst4), .clear(clr4), .bus(if4.slave), .odd_row(odd4), .pair_cnt(pc4));
    maxpool_stream #(.DATA_W(16), .ROW_LEN(2), .SIGNED(1)) u2 (
        .clk(clk), .rst(rst2), .clear(clr2), .bus(if2.slave), .odd_row(odd2), .pair_cnt(pc2));
    maxpool_stream #(.DATA_W(16), .ROW_LEN(16), .SIGNED(0)) u16 (
        .clk(clk), .rst(rst16), .clear(clr16), .bus(if16.slave), .odd_row(odd16), .pair_cnt(pc16));

    logic [15:0] exp4_q[$];
    logic [15:0] exp2_q[$];
    logic [15:0] exp16_q[$];
    bit          ep4, ep2, ep16;
    logic [15:0] last4, last2, last16;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic check_dut(input int u);
        logic        v;
        logic [15:0] d;
        bit          ep;
        logic [15:0] e;
        logic [15:0] last;
        int          sz;
        v = 1'b0; d = '0; ep = 1'b0; last = '0; sz = 0; e = '0;
        case (u)
            0: begin v = if4.DO_valid;  d = if4.DO;  ep = ep4;  last = last4;  sz = exp4_q.size();  end
            1: begin v = if2.DO_valid;  d = if2.DO;  ep = ep2;  last = last2;  sz = exp2_q.size();  end
            default: begin v = if16.DO_valid; d = if16.DO; ep = ep16; last = last16; sz = exp16_q.size(); end
        endcase
        chk($sformatf("u%0d_do_valid", u), {31'd0, v}, {31'd0, ep});
        if (v === 1'b1) begin
            chk($sformatf("u%0d_pulse_expected", u), (sz > 0) ? 32'd1 : 32'd0, 32'd1);
            if (sz > 0) begin
                case (u)
                    0: e = exp4_q.pop_front();
                    1: e = exp2_q.pop_front();
                    default: e = exp16_q.pop_front();
                endcase
                chk($sformatf("u%0d_do", u), {16'd0, d}, {16'd0, e});
                case (u)
                    0: last4 = e;
                    1: last2 = e;
                    default: last16 = e;
                endcase
            end
        end else begin
            chk($sformatf("u%0d_do_hold", u), {16'd0, d}, {16'd0, last});
        end
    endtask

    // One clock: sample outputs #1 after the edge, then return inputs to idle
    task automatic tick();
        @(posedge clk);
        #1;
        check_dut(0);
        check_dut(1);
        check_dut(2);
        if4.DI_valid = 1'b0;  if2.DI_valid = 1'b0;  if16.DI_valid = 1'b0;
        if4.DI = 16'($urandom); if2.DI = 16'($urandom); if16.DI = 16'($urandom);
        clr4 = 1'b0; clr2 = 1'b0; clr16 = 1'b0;
        rst4 = 1'b0; rst2 = 1'b0; rst16 = 1'b0;
        ep4 = 1'b0; ep2 = 1'b0; ep16 = 1'b0;
    endtask

    task automatic send(input int u, input logic [15:0] d, input bit out,
                        input logic [15:0] e, input bit clr = 1'b0);
        case (u)
            0: begin
                if4.DI_valid = 1'b1; if4.DI = d; clr4 = clr;
                if (out) begin exp4_q.push_back(e); ep4 = 1'b1; end
            end
            1: begin
                if2.DI_valid = 1'b1; if2.DI = d; clr2 = clr;
                if (out) begin exp2_q.push_back(e); ep2 = 1'b1; end
            end
            default: begin
                if16.DI_valid = 1'b1; if16.DI = d; clr16 = clr;
                if (out) begin exp16_q.push_back(e); ep16 = 1'b1; end
            end
        endcase
        tick();
    endtask

    function automatic logic [15:0] umax4(input logic [15:0] a, input logic [15:0] b,
                                          input logic [15:0] c, input logic [15:0] d);
        logic [15:0] m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    // One ROW_LEN=4 row pair into u4, optionally with an idle cycle after each word
    task automatic pair4(input logic [15:0] a0, input logic [15:0] a1,
                         input logic [15:0] a2, input logic [15:0] a3,
                         input logic [15:0] b0, input logic [15:0] b1,
                         input logic [15:0] b2, input logic [15:0] b3,
                         input bit gap);
        logic [15:0] r0 [4];
        logic [15:0] r1 [4];
        r0[0] = a0; r0[1] = a1; r0[2] = a2; r0[3] = a3;
        r1[0] = b0; r1[1] = b1; r1[2] = b2; r1[3] = b3;
        for (int i = 0; i < 4; i++) begin
            send(0, r0[i], 1'b0, 16'd0);
            if (gap) tick();
        end
        chk("u4_odd_row_after_row0", {31'd0, odd4}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 1) send(0, r1[i], 1'b1, umax4(r0[i-1], r0[i], r1[i-1], r1[i]));
            else            send(0, r1[i], 1'b0, 16'd0);
            if (gap) tick();
        end
        chk("u4_odd_row_after_row1", {31'd0, odd4}, 32'd0);
    endtask

    logic [15:0] relu_exp;

    initial begin
        if4.DI_valid = 1'b0;  if2.DI_valid = 1'b0;  if16.DI_valid = 1'b0;
        if4.DI = '0; if2.DI = '0; if16.DI = '0;
        clr4 = 1'b0; clr2 = 1'b0; clr16 = 1'b0;
        ep4 = 1'b0; ep2 = 1'b0; ep16 = 1'b0;
        last4 = '0; last2 = '0; last16 = '0;

        // Reset all instances
        rst4 = 1'b1; rst2 = 1'b1; rst16 = 1'b1;
        tick();
        chk("u4_rst_odd_row", {31'd0, odd4}, 32'd0);
        chk("u4_rst_pair_cnt", {16'd0, pc4}, 32'd0);
        chk("u2_rst_odd_row", {31'd0, odd2}, 32'd0);
        chk("u2_rst_pair_cnt", {16'd0, pc2}, 32'd0);
        chk("u16_rst_odd_row", {31'd0, odd16}, 32'd0);
        chk("u16_rst_pair_cnt", {16'd0, pc16}, 32'd0);

        // Full-rate row pair: outputs 5 then 9
        pair4(16'd1, 16'd5, 16'd2, 16'd3, 16'd4, 16'd0, 16'd9, 16'd8, 1'b0);
        chk("u4_pair_cnt_full_rate", {16'd0, pc4}, 32'd1);

        // Same data with bubbles on alternate cycles
        pair4(16'd1, 16'd5, 16'd2, 16'd3, 16'd4, 16'd0, 16'd9, 16'd8, 1'b1);
        chk("u4_pair_cnt_bubbles", {16'd0, pc4}, 32'd2);

        // Signed compare, ROW_LEN=2: all negative
`ifdef MAXPOOL_STREAM_RELU_EN
        relu_exp = 16'h0000;
`else
        relu_exp = 16'hFFFF;
`endif
        send(1, 16'hFFFE, 1'b0, 16'd0);
        send(1, 16'hFFFF, 1'b0, 16'd0);
        chk("u2_odd_row", {31'd0, odd2}, 32'd1);
        send(1, 16'h8000, 1'b0, 16'd0);
        send(1, 16'hFFFD, 1'b1, relu_exp);
        chk("u2_pair_cnt_1", {16'd0, pc2}, 32'd1);
        // Mixed signs: the signed maximum is 0x7FFF (an unsigned compare would pick 0xFFFF)
        send(1, 16'h0003, 1'b0, 16'd0);
        send(1, 16'h8001, 1'b0, 16'd0);
        send(1, 16'h7FFF, 1'b0, 16'd0);
        send(1, 16'hFFFF, 1'b1, 16'h7FFF);
        chk("u2_pair_cnt_2", {16'd0, pc2}, 32'd2);

        // Clear during Row1, together with a valid word that must be dropped
        send(0, 16'd1, 1'b0, 16'd0);
        send(0, 16'd5, 1'b0, 16'd0);
        send(0, 16'd2, 1'b0, 16'd0);
        send(0, 16'd3, 1'b0, 16'd0);
        send(0, 16'd4, 1'b0, 16'd0);
        send(0, 16'd0, 1'b1, 16'd5);
        send(0, 16'd9, 1'b0, 16'd0);
        send(0, 16'd8, 1'b0, 16'd0, 1'b1);
        chk("u4_clear_odd_row", {31'd0, odd4}, 32'd0);
        chk("u4_clear_pair_cnt", {16'd0, pc4}, 32'd0);
        tick();
        pair4(16'd7, 16'd2, 16'd0, 16'd1, 16'd3, 16'd6, 16'd4, 16'd10, 1'b0);
        chk("u4_pair_cnt_after_clear", {16'd0, pc4}, 32'd1);

        // Reset in the middle of Row0, then a full 16x16 frame with random bubbles
        send(2, 16'd100, 1'b0, 16'd0);
        send(2, 16'd101, 1'b0, 16'd0);
        send(2, 16'd102, 1'b0, 16'd0);
        rst16 = 1'b1;
        last16 = '0;
        tick();
        chk("u16_rst_mid_odd_row", {31'd0, odd16}, 32'd0);
        for (int r = 0; r < 16; r++) begin
            for (int c = 0; c < 16; c++) begin
                send(2, 16'(r * 16 + c), ((r % 2) == 1) && ((c % 2) == 1), 16'(r * 16 + c));
                if ($urandom_range(0, 3) == 0) tick();
            end
            if (r == 7) chk("u16_pair_cnt_mid", {16'd0, pc16}, 32'd4);
        end
        tick();
        chk("u16_pair_cnt_frame", {16'd0, pc16}, 32'd8);
        chk("u16_odd_row_frame", {31'd0, odd16}, 32'd0);

        chk("u4_queue_drained", exp4_q.size(), 32'd0);
        chk("u2_queue_drained", exp2_q.size(), 32'd0);
        chk("u16_queue_drained", exp16_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/maxpool_stream.md
Name: maxpool_stream

Overview:
- Streaming 2x2, stride-2 max-pool engine.
- Sits on the consumer end of the DI_valid/DI word stream that the top-level sequencer reads out of GBUFF_A.
- Emits pooled words on DO_valid/DO, which the sequencer writes into GBUFF_B.
- Input arrives row-major, ROW_LEN words per row with arbitrary bubbles. One output word is produced per 2x2 window, so there are ROW_LEN/2 outputs per row pair.

Parameters:
- DATA_W, 16: word width in bits.
- ROW_LEN, 16: words per input row; must be even and ≥2.
- SIGNED, 0: 1 = compare as two's-complement, 0 = unsigned.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- clear  in  1  synchronous resync: returns the FSM and counters to the start of a row pair; line buffer contents are don't-care.
- DI_valid  in  1  input word qualifier; one word is accepted per cycle when high.
- DI  in  DATA_W  input word.
- DO_valid  out  1  one-cycle pulse per pooled word.
- DO  out  DATA_W  pooled word, valid while DO_valid=1.
- odd_row  out  1  high while the FSM is in ST_ODD (status only).
- pair_cnt  out  16  completed row pairs since reset/clear; wraps at 0xFFFF.

Behaviour:
- Reset: one clock; rst=1 sampled at a clock edge. Reset values: DO_valid=0, DO=0, odd_row=0, pair_cnt=0, col=0, hold=0, state=ST_EVEN. The line buffer is not reset.
- Reset mid-row discards the partial window. No output is produced for it.
- Internal state:
  - col counter, 0..ROW_LEN-1.
  - hold register: the even-column word.
  - linebuf of ROW_LEN/2 entries × DATA_W, implemented as flops.
- Comparison: max(a,b) = (a≥b) ? a : b, signed or unsigned per SIGNED. On a tie the value is identical, so no priority is needed.
- Accepted word (DI_valid=1, clear=0, rst=0):
  - col even: hold<=DI.
  - col odd: h = max(hold, DI).
  - col advances; col==ROW_LEN-1 wraps to 0.
- ST_EVEN, col odd: linebuf[col>>1]<=h. No output.
- ST_ODD, col odd: DO<=max(linebuf[col>>1], h) and DO_valid<=1 on the next edge. Latency is exactly 1 cycle after the accepting edge.
- Transitions:
  - ST_EVEN→ST_ODD on acceptance of col==ROW_LEN-1.
  - ST_ODD→ST_EVEN on acceptance of col==ROW_LEN-1; pair_cnt increments on the same edge.
  - Otherwise the state holds.
- DI_valid=0: no state change. DO_valid=0 on the next cycle. DO holds its last value.
- clear=1: col=0, state=ST_EVEN, pair_cnt=0, DO_valid=0 next cycle. A DI word in the same cycle is dropped (clear wins). rst has priority over clear.
- Back-to-back input at full rate gives ROW_LEN/2 DO pulses per odd row, spaced 2 cycles apart.
- No backpressure: the consumer must accept every pulse.

Optional Feature:
- Macro: MAXPOOL_STREAM_RELU_EN.
- Defined: final output is clamped, DO = (SIGNED && result<0) ? 0 : result, in the same cycle with no added latency. With SIGNED=0 it has no effect.
- Undefined: DO is the raw max.

Test Plan:
- ROW_LEN=4, unsigned, full rate. Row0=1,5,2,3; Row1=4,0,9,8 → DO=5 then 9, one cycle after the 2nd and 4th Row1 words; pair_cnt=1.
- Same data with DI_valid low on alternating cycles → identical DO sequence. DO_valid pulses are 1 cycle wide; no pulses during Row0.
- SIGNED=1, ROW_LEN=2, Row0=0xFFFE,0xFFFF, Row1=0x8000,0xFFFD → DO=0xFFFF. With MAXPOOL_STREAM_RELU_EN defined → DO=0x0000.
- clear asserted after 3 words of Row1 together with a valid word → that word is dropped; odd_row=0, pair_cnt=0. A fresh Row0/Row1 then produces correct outputs.
- rst asserted mid-Row0, then a full 16x16 frame with value=row*16+col (ROW_LEN=16) → 64 outputs, output (i,j)=(2i+1)*16+2j+1; pair_cnt=8.
